// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered instruction decode stage with skid buffer
// Extracts opcode/register/immediate fields at accept and holds them in a 2-entry output/skid buffer.
module instr_decode_stage #(
  parameter int INSTR_W   = 9,
  parameter int OP_W      = 3,
  parameter int REG_W     = 2,
  parameter int IMM_SRC_W = 7,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               imm_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_W-1:0]   r_a,
  output logic [REG_W-1:0]   r_b,
  output logic [DATA_W-1:0]  immediate,
  output logic [CNT_W-1:0]   decoded_count
);

  localparam int ENT_W = OP_W + 2 * REG_W + DATA_W;

  logic [ENT_W-1:0]  dec_ent;
  logic [ENT_W-1:0]  or_q, or_d, sk_q, sk_d;
  logic              or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] imm_ext;
  logic              accept, emit;
  logic              unused_instr_bits;

  // Instruction bits above the field map carry no information for this stage.
  assign unused_instr_bits = ^instruction;

  always_comb begin
    imm_ext = '0;
    if (!imm_mode && instruction[IMM_SRC_W-1]) begin
      imm_ext = '1;
    end
    imm_ext[IMM_SRC_W-1:0] = instruction[IMM_SRC_W-1:0];
  end

  assign dec_ent = {instruction[2*REG_W+OP_W-1:2*REG_W],
                    instruction[2*REG_W-1:REG_W],
                    instruction[REG_W-1:0],
                    imm_ext};

  assign in_ready  = !sk_valid_q;
  assign out_valid = or_valid_q;
  assign accept    = in_valid && in_ready;
  assign emit      = or_valid_q && out_ready;

  always_comb begin
    or_d       = or_q;
    sk_d       = sk_q;
    or_valid_d = or_valid_q;
    sk_valid_d = sk_valid_q;
    cnt_d      = (emit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || emit) begin
      // The skid entry is older than anything arriving now, so it drains first.
      if (sk_valid_q) begin
        or_d       = sk_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_d       = dec_ent;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_d       = dec_ent;
      sk_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign {opcode, r_a, r_b, immediate} = or_q;
  assign decoded_count = cnt_q;

endmodule
